// File: rtl/pulse_param_loader.sv
// UART frame loader for pulse-sequencer timing parameters.
// Checked frames fill shadow registers; a commit frame copies them all to the live outputs in one clock.
module pulse_param_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [31:0] o_per,
    output logic [15:0] o_p1wid,
    output logic [15:0] o_del,
    output logic [15:0] o_p2wid,
    output logic [15:0] o_p1wid2,
    output logic [15:0] o_del2,
    output logic [15:0] o_p2wid2,
    output logic [15:0] o_p1st2,
    output logic [15:0] o_nut_d,
    output logic [15:0] o_p_bl_hf,
    output logic [7:0]  o_nut_w,
    output logic [7:0]  o_cp,
    output logic [7:0]  o_p_bl,
    output logic [6:0]  o_pr_att,
    output logic [6:0]  o_po_att,
    output logic        o_bl,
    output logic        o_phsub,
    output logic        o_upd,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [7:0]  o_err_cnt
);

    // state  | meaning
    // S_IDLE | waiting for the 0xA5 sync byte
    // S_ADDR | next byte is the register address
    // S_DATA | collecting N data bytes, LSB first
    // S_CHK  | next byte is the XOR checksum
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_TC = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] COMMIT_ADDR = 8'h10;

    state_t          r_state;
    state_t          w_state_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [2:0]      r_byte_cnt;
    logic [2:0]      r_n;
    logic [7:0]      r_addr;
    logic [7:0]      r_chk;
    logic [31:0]     r_data_buf;
    logic            r_upd;
    logic            r_frame_ok;
    logic            r_frame_err;
    logic [7:0]      r_err_cnt;

    logic            w_addr_ok;
    logic [2:0]      w_addr_n;
    logic            w_timeout;
    logic            w_ok;
    logic            w_err;
    logic            w_commit;
    logic            w_shadow_wr;

    logic [31:0] r_sh_per,    r_lv_per;
    logic [15:0] r_sh_p1wid,  r_lv_p1wid;
    logic [15:0] r_sh_del,    r_lv_del;
    logic [15:0] r_sh_p2wid,  r_lv_p2wid;
    logic [15:0] r_sh_p1wid2, r_lv_p1wid2;
    logic [15:0] r_sh_del2,   r_lv_del2;
    logic [15:0] r_sh_p2wid2, r_lv_p2wid2;
    logic [15:0] r_sh_p1st2,  r_lv_p1st2;
    logic [15:0] r_sh_nut_d,  r_lv_nut_d;
    logic [15:0] r_sh_p_bl_hf, r_lv_p_bl_hf;
    logic [7:0]  r_sh_nut_w,  r_lv_nut_w;
    logic [7:0]  r_sh_cp,     r_lv_cp;
    logic [7:0]  r_sh_p_bl,   r_lv_p_bl;
    logic [6:0]  r_sh_pr_att, r_lv_pr_att;
    logic [6:0]  r_sh_po_att, r_lv_po_att;
    logic        r_sh_bl,     r_lv_bl;
    logic        r_sh_phsub,  r_lv_phsub;

    // Address map: payload length per register, and whether the address exists at all.
    always_comb begin
        w_addr_ok = 1'b1;
        w_addr_n  = 3'd0;
        case (i_rx_data)
            8'h00:                             w_addr_n = 3'd4;
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h06, 8'h07, 8'h09, 8'h0E:        w_addr_n = 3'd2;
            8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
            8'h0F:                             w_addr_n = 3'd1;
            8'h10:                             w_addr_n = 3'd0;
            default:                           w_addr_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A byte arriving on the terminal-count cycle suppresses the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_rx_valid && (r_to_cnt == TO_TC);

    always_comb begin
        w_state_next = r_state;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    if (!w_addr_ok) begin
                        w_state_next = S_IDLE;
                        w_err        = 1'b1;
                    end else if (w_addr_n == 3'd0) begin
                        w_state_next = S_CHK;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (i_rx_valid && ((r_byte_cnt + 3'd1) == r_n)) begin
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (i_rx_valid) begin
                    w_state_next = S_IDLE;
                    if (i_rx_data == r_chk) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_err        = 1'b1;
        end
    end

    assign w_commit    = w_ok && (r_addr == COMMIT_ADDR);
    assign w_shadow_wr = w_ok && (r_addr != COMMIT_ADDR);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt    <= '0;
            r_byte_cnt  <= 3'd0;
            r_n         <= 3'd0;
            r_addr      <= 8'd0;
            r_chk       <= 8'd0;
            r_data_buf  <= 32'd0;
            r_upd       <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            if ((r_state == S_IDLE) || i_rx_valid) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_TC) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            r_upd       <= w_commit;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            if (i_rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        r_data_buf <= 32'd0;
                        r_byte_cnt <= 3'd0;
                    end
                    S_ADDR: begin
                        r_addr     <= i_rx_data;
                        r_n        <= w_addr_n;
                        r_chk      <= i_rx_data;
                        r_byte_cnt <= 3'd0;
                    end
                    S_DATA: begin
                        r_data_buf[{r_byte_cnt[1:0], 3'b000} +: 8] <= i_rx_data;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_chk      <= r_chk ^ i_rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sh_per     <= 32'd10000;
            r_sh_p1wid   <= 16'd30;
            r_sh_del     <= 16'd200;
            r_sh_p2wid   <= 16'd60;
            r_sh_p1wid2  <= 16'd0;
            r_sh_del2    <= 16'd0;
            r_sh_p2wid2  <= 16'd0;
            r_sh_p1st2   <= 16'd0;
            r_sh_nut_d   <= 16'd0;
            r_sh_p_bl_hf <= 16'd50;
            r_sh_nut_w   <= 8'd0;
            r_sh_cp      <= 8'd1;
            r_sh_p_bl    <= 8'd100;
            r_sh_pr_att  <= 7'd0;
            r_sh_po_att  <= 7'd0;
            r_sh_bl      <= 1'b1;
            r_sh_phsub   <= 1'b0;
        end else if (w_shadow_wr) begin
            case (r_addr)
                8'h00: r_sh_per     <= r_data_buf;
                8'h01: r_sh_p1wid   <= r_data_buf[15:0];
                8'h02: r_sh_del     <= r_data_buf[15:0];
                8'h03: r_sh_p2wid   <= r_data_buf[15:0];
                8'h04: r_sh_p1wid2  <= r_data_buf[15:0];
                8'h05: r_sh_del2    <= r_data_buf[15:0];
                8'h06: r_sh_p2wid2  <= r_data_buf[15:0];
                8'h07: r_sh_p1st2   <= r_data_buf[15:0];
                8'h08: r_sh_nut_w   <= r_data_buf[7:0];
                8'h09: r_sh_nut_d   <= r_data_buf[15:0];
                8'h0A: r_sh_pr_att  <= r_data_buf[6:0];
                8'h0B: r_sh_po_att  <= r_data_buf[6:0];
                8'h0C: r_sh_cp      <= r_data_buf[7:0];
                8'h0D: r_sh_p_bl    <= r_data_buf[7:0];
                8'h0E: r_sh_p_bl_hf <= r_data_buf[15:0];
                8'h0F: begin
                    r_sh_bl    <= r_data_buf[0];
                    r_sh_phsub <= r_data_buf[1];
                end
                default: ;
            endcase
        end
    end

    // Live set only moves on commit so the pulse engine never sees a half-updated frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lv_per     <= 32'd10000;
            r_lv_p1wid   <= 16'd30;
            r_lv_del     <= 16'd200;
            r_lv_p2wid   <= 16'd60;
            r_lv_p1wid2  <= 16'd0;
            r_lv_del2    <= 16'd0;
            r_lv_p2wid2  <= 16'd0;
            r_lv_p1st2   <= 16'd0;
            r_lv_nut_d   <= 16'd0;
            r_lv_p_bl_hf <= 16'd50;
            r_lv_nut_w   <= 8'd0;
            r_lv_cp      <= 8'd1;
            r_lv_p_bl    <= 8'd100;
            r_lv_pr_att  <= 7'd0;
            r_lv_po_att  <= 7'd0;
            r_lv_bl      <= 1'b1;
            r_lv_phsub   <= 1'b0;
        end else if (w_commit) begin
            r_lv_per     <= r_sh_per;
            r_lv_p1wid   <= r_sh_p1wid;
            r_lv_del     <= r_sh_del;
            r_lv_p2wid   <= r_sh_p2wid;
            r_lv_p1wid2  <= r_sh_p1wid2;
            r_lv_del2    <= r_sh_del2;
            r_lv_p2wid2  <= r_sh_p2wid2;
            r_lv_p1st2   <= r_sh_p1st2;
            r_lv_nut_d   <= r_sh_nut_d;
            r_lv_p_bl_hf <= r_sh_p_bl_hf;
            r_lv_nut_w   <= r_sh_nut_w;
            r_lv_cp      <= r_sh_cp;
            r_lv_p_bl    <= r_sh_p_bl;
            r_lv_pr_att  <= r_sh_pr_att;
            r_lv_po_att  <= r_sh_po_att;
            r_lv_bl      <= r_sh_bl;
            r_lv_phsub   <= r_sh_phsub;
        end
    end

    assign o_per       = r_lv_per;
    assign o_p1wid     = r_lv_p1wid;
    assign o_del       = r_lv_del;
    assign o_p2wid     = r_lv_p2wid;
    assign o_p1wid2    = r_lv_p1wid2;
    assign o_del2      = r_lv_del2;
    assign o_p2wid2    = r_lv_p2wid2;
    assign o_p1st2     = r_lv_p1st2;
    assign o_nut_d     = r_lv_nut_d;
    assign o_p_bl_hf   = r_lv_p_bl_hf;
    assign o_nut_w     = r_lv_nut_w;
    assign o_cp        = r_lv_cp;
    assign o_p_bl      = r_lv_p_bl;
    assign o_pr_att    = r_lv_pr_att;
    assign o_po_att    = r_lv_po_att;
    assign o_bl        = r_lv_bl;
    assign o_phsub     = r_lv_phsub;
    assign o_upd       = r_upd;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: doc/pulse_param_loader.md
PULSE_PARAM_LOADER -- requirements
Module: pulse_param_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000: idle cycles inside a frame before it is aborted.
REQ-002 clk  input  1  system clock, 50 MHz domain; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  byte from the UART receiver.
REQ-005 rx_valid  input  1  rx_data valid this cycle; one byte per asserted cycle.
REQ-006 per  output  32  period, cycles.
REQ-007 p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d, p_bl_hf  output  16 each  pulse timing words, cycles.
REQ-008 nut_w, cp, p_bl  output  8 each  nutation width, CPMG count (0=CW), post-pulse block start.
REQ-009 pr_att, po_att  output  7 each  attenuator codes.
REQ-010 bl, phsub  output  1 each  block enable, phase-cycling enable.
REQ-011 upd  output  1  one-cycle pulse when live outputs change.
REQ-012 frame_ok, frame_err  output  1 each  one-cycle frame result pulses.
REQ-013 err_cnt  output  8  saturating count of rejected frames.

Function
REQ-014 Frame format SHALL be: 0xA5, ADDR, N data bytes LSB first, CHK; CHK = XOR of ADDR and all data bytes.
REQ-015 N SHALL be: ADDR 0x00 per=4; 0x01 p1wid, 0x02 del, 0x03 p2wid, 0x04 p1wid2, 0x05 del2, 0x06 p2wid2, 0x07 p1st2, 0x09 nut_d, 0x0E p_bl_hf = 2; 0x08 nut_w, 0x0A pr_att, 0x0B po_att, 0x0C cp, 0x0D p_bl, 0x0F flags = 1; 0x10 commit = 0.
REQ-016 For 7-bit targets the module SHALL write data[6:0] and ignore bit 7. For flags it SHALL set bl=bit0 and phsub=bit1 and ignore bits 7:2.
REQ-017 FSM states SHALL be IDLE, ADDR, DATA, CHK. IDLE->ADDR on byte 0xA5. Other bytes in IDLE SHALL be ignored silently.
REQ-018 ADDR: an address in the map SHALL go to DATA when N>0, else to CHK. An unmapped address SHALL go to IDLE with a frame_err pulse.
REQ-019 DATA SHALL collect exactly N bytes using a byte counter, then go to CHK. 0xA5 inside a frame SHALL be treated as ordinary data.
REQ-020 CHK: a matching byte SHALL pulse frame_ok and apply the frame. A mismatch SHALL pulse frame_err and write nothing. Both cases return to IDLE.
REQ-021 A valid non-commit frame SHALL write only the shadow register for ADDR. Live outputs SHALL NOT change.
REQ-022 A valid commit frame SHALL copy every shadow register to the live outputs in one clock and pulse upd.
REQ-023 Latency: frame_ok/frame_err, the shadow or live write, and upd SHALL all be visible in the cycle following the edge that samples CHK.
REQ-024 A timeout counter SHALL clear on every rx_valid and in IDLE. Reaching TIMEOUT_CYCLES-1 outside IDLE without rx_valid SHALL return the FSM to IDLE with a frame_err pulse.
REQ-025 If rx_valid coincides with the timeout terminal count, the byte SHALL win and no timeout occurs.
REQ-026 err_cnt SHALL increment on every frame_err pulse and saturate at 255.
REQ-027 Live outputs SHALL be glitch-free registers held stable between commits, since the pulse engine samples them continuously.

Reset
REQ-028 On reset assertion, the FSM, byte counter, timeout counter, CHK accumulator, upd, frame_ok, frame_err and err_cnt SHALL go to IDLE/0 immediately and asynchronously.
REQ-029 On reset, shadow and live registers SHALL take these values: per=10000, p1wid=30, del=200, p2wid=60, p_bl=100, p_bl_hf=50, cp=1, bl=1. All other outputs SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no frame_err pulse and no shadow write.

Verification
REQ-031 Scenario: send A5 01 64 00 65, then A5 10 10 -> frame_ok twice; p1wid stays 30 until the commit frame; then p1wid=100 with one upd pulse.
REQ-032 Scenario: send A5 00 40 0D 03 00 4E, then commit -> per=200000.
REQ-033 Scenario: send A5 02 C8 00 CB (bad CHK) -> frame_err, err_cnt=1; commit leaves del=200.
REQ-034 Scenario: send A5 0A, then no bytes for TIMEOUT_CYCLES -> frame_err and FSM in IDLE; a following valid frame is accepted.
REQ-035 Scenario: send A5 22 -> frame_err immediately. Then send 300 unmapped frames -> err_cnt holds at 255.
REQ-036 Scenario: write p_bl shadow, assert reset mid-frame, then commit -> all outputs at reset defaults with no spurious pulses.
